// File: rtl/rram_ctrl_seq_if.sv
// Host/array-side signal bundle for the RRAM sequencing controller.
// master = host and array periphery, slave = rram_ctrl_seq.
interface rram_ctrl_seq_if #(
    parameter int B_SIZE = 2,
    parameter int X_SIZE = 4,
    parameter int Y_SIZE = 5
);
    logic                      EN;
    logic                      RW;
    logic [X_SIZE-1:0]         X_ADDRESS_IN;
    logic [Y_SIZE-1:0]         Y_ADDRESS_IN;
    logic [B_SIZE-1:0]         DATA_IN;
    logic [B_SIZE-1:0]         SA_OUT;
    logic                      READY;
    logic [(1<<X_SIZE)-1:0]    P_DECODER_OUT;
    logic [(1<<X_SIZE)-1:0]    NOT_P_DECODER_OUT;
    logic [(1<<X_SIZE)-1:0]    N_DECODER_OUT;
    logic [(1<<X_SIZE)-1:0]    NOT_N_DECODER_OUT;
    logic [(1<<Y_SIZE)-1:0]    Y_DECODER_OUT;
    logic                      P_EN_REF;
    logic                      NOT_P_EN_REF;
    logic [B_SIZE-1:0]         WRITE_DATA;
    logic                      READ;
    logic                      WRITE;
    logic                      PRE;
    logic                      DVLP;
    logic                      EN_SA;
    logic [B_SIZE-1:0]         DATA_OUT;
    logic                      DATA_VALID;
    logic                      WRITE_DONE;
    logic                      ERROR;

    modport master (
        output EN, RW, X_ADDRESS_IN, Y_ADDRESS_IN, DATA_IN, SA_OUT,
        input  READY, P_DECODER_OUT, NOT_P_DECODER_OUT,
        input  N_DECODER_OUT, NOT_N_DECODER_OUT, Y_DECODER_OUT,
        input  P_EN_REF, NOT_P_EN_REF, WRITE_DATA,
        input  READ, WRITE, PRE, DVLP, EN_SA,
        input  DATA_OUT, DATA_VALID, WRITE_DONE, ERROR
    );

    modport slave (
        input  EN, RW, X_ADDRESS_IN, Y_ADDRESS_IN, DATA_IN, SA_OUT,
        output READY, P_DECODER_OUT, NOT_P_DECODER_OUT,
        output N_DECODER_OUT, NOT_N_DECODER_OUT, Y_DECODER_OUT,
        output P_EN_REF, NOT_P_EN_REF, WRITE_DATA,
        output READ, WRITE, PRE, DVLP, EN_SA,
        output DATA_OUT, DATA_VALID, WRITE_DONE, ERROR
    );
endinterface

// File: rtl/rram_ctrl_seq.sv
// RRAM array sequencing controller: programmable read/write phases.
// Define RRAM_CTRL_VERIFY_EN to add the program-and-verify loop.
module rram_ctrl_seq #(
    parameter int B_SIZE       = 2,
    parameter int X_SIZE       = 4,
    parameter int Y_SIZE       = 5,
    parameter int PRE_CYCLES   = 1,
    parameter int DVLP_CYCLES  = 1,
    parameter int SENSE_CYCLES = 1,
    parameter int WRITE_CYCLES = 2,
    parameter int MAX_RETRY    = 3
) (
    input logic           clk,
    input logic           reset,
    rram_ctrl_seq_if.slave bus
);
    localparam int XW = 1 << X_SIZE;
    localparam int YW = 1 << Y_SIZE;

    localparam int M1 = (PRE_CYCLES > DVLP_CYCLES) ? PRE_CYCLES : DVLP_CYCLES;
    localparam int M2 = (SENSE_CYCLES > WRITE_CYCLES) ? SENSE_CYCLES : WRITE_CYCLES;
    localparam int MC = (M1 > M2) ? M1 : M2;
    localparam int CW = $clog2(MC) + 1;

    localparam logic [CW-1:0] PRE_LD   = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] DVLP_LD  = CW'(DVLP_CYCLES - 1);
    localparam logic [CW-1:0] SENSE_LD = CW'(SENSE_CYCLES - 1);
    localparam logic [CW-1:0] WRITE_LD = CW'(WRITE_CYCLES - 1);

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_RPH1 = 3'b001;
    localparam logic [2:0] S_RPH2 = 3'b010;
    localparam logic [2:0] S_RPH3 = 3'b011;
    localparam logic [2:0] S_WPH1 = 3'b100;
    localparam logic [2:0] S_VFY  = 3'b101;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [X_SIZE-1:0] x_q, x_d;
    logic [Y_SIZE-1:0] y_q, y_d;
    logic [B_SIZE-1:0] wdata_q, wdata_d;
    logic [B_SIZE-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
    logic              wdone_q, wdone_d;
    logic              ready_q, ready_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              pre_q, pre_d;
    logic              dvlp_q, dvlp_d;
    logic              ensa_q, ensa_d;
    logic              pref_q, pref_d;
    logic [XW-1:0]     pdec_q, pdec_d;
    logic [XW-1:0]     ndec_q, ndec_d;
    logic [YW-1:0]     ydec_q, ydec_d;
    logic              v_pre, v_dvlp, v_sense, in_vfy;

`ifdef RRAM_CTRL_VERIFY_EN
    localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [1:0]     vph_q, vph_d;
    logic [RTW-1:0] retry_q, retry_d;
    logic           err_q, err_d;
`endif

    // Next-state, phase timing and registered output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        wdata_d  = wdata_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        wdone_d  = 1'b0;
`ifdef RRAM_CTRL_VERIFY_EN
        vph_d    = vph_q;
        retry_d  = retry_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.EN && ready_q) begin
                    x_d = bus.X_ADDRESS_IN;
                    y_d = bus.Y_ADDRESS_IN;
`ifdef RRAM_CTRL_VERIFY_EN
                    retry_d = '0;
`endif
                    if (bus.RW) begin
                        state_d = S_RPH1;
                        cnt_d   = PRE_LD;
                    end else begin
                        state_d = S_WPH1;
                        cnt_d   = WRITE_LD;
                        wdata_d = bus.DATA_IN;
                    end
                end
            end
            S_RPH1: begin
                if (cnt_q == '0) begin
                    state_d = S_RPH2;
                    cnt_d   = DVLP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RPH2: begin
                if (cnt_q == '0) begin
                    state_d = S_RPH3;
                    cnt_d   = SENSE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RPH3: begin
                if (cnt_q == '0) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    dout_d   = bus.SA_OUT;
                    dvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WPH1: begin
                if (cnt_q == '0) begin
`ifdef RRAM_CTRL_VERIFY_EN
                    state_d = S_VFY;
                    vph_d   = 2'd0;
                    cnt_d   = PRE_LD;
`else
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    wdone_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef RRAM_CTRL_VERIFY_EN
            S_VFY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (vph_q == 2'd0) begin
                    vph_d = 2'd1;
                    cnt_d = DVLP_LD;
                end else if (vph_q == 2'd1) begin
                    vph_d = 2'd2;
                    cnt_d = SENSE_LD;
                end else if (bus.SA_OUT == wdata_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    wdone_d = 1'b1;
                end else if (retry_q < RTW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_WPH1;
                    cnt_d   = WRITE_LD;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    wdone_d = 1'b1;
                    err_d   = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        in_vfy  = 1'b0;
        v_pre   = 1'b0;
        v_dvlp  = 1'b0;
        v_sense = 1'b0;
`ifdef RRAM_CTRL_VERIFY_EN
        in_vfy  = (state_d == S_VFY);
        v_pre   = in_vfy && (vph_d == 2'd0);
        v_dvlp  = in_vfy && (vph_d == 2'd1);
        v_sense = in_vfy && (vph_d == 2'd2);
`endif
        ready_d = (state_d == S_IDLE);
        pre_d   = (state_d == S_RPH1) || v_pre;
        dvlp_d  = (state_d == S_RPH2) || v_dvlp;
        ensa_d  = (state_d == S_RPH3) || v_sense;
        read_d  = pre_d || dvlp_d || ensa_d;
        pref_d  = read_d;
        write_d = (state_d == S_WPH1);
        pdec_d  = ready_d ? '0 : (XW'(1) << x_d);
        ndec_d  = write_d ? (XW'(1) << x_d) : '0;
        ydec_d  = ready_d ? '0 : (YW'(1) << y_d);
    end

    // State, counter, latched request and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            wdata_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            ready_q  <= 1'b1;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            pre_q    <= 1'b0;
            dvlp_q   <= 1'b0;
            ensa_q   <= 1'b0;
            pref_q   <= 1'b0;
            pdec_q   <= '0;
            ndec_q   <= '0;
            ydec_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            wdata_q  <= wdata_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            wdone_q  <= wdone_d;
            ready_q  <= ready_d;
            read_q   <= read_d;
            write_q  <= write_d;
            pre_q    <= pre_d;
            dvlp_q   <= dvlp_d;
            ensa_q   <= ensa_d;
            pref_q   <= pref_d;
            pdec_q   <= pdec_d;
            ndec_q   <= ndec_d;
            ydec_q   <= ydec_d;
        end
    end

`ifdef RRAM_CTRL_VERIFY_EN
    // Verify sub-phase, retry count and error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vph_q   <= 2'd0;
            retry_q <= '0;
            err_q   <= 1'b0;
        end else begin
            vph_q   <= vph_d;
            retry_q <= retry_d;
            err_q   <= err_d;
        end
    end

    assign bus.ERROR = err_q;
`else
    assign bus.ERROR = 1'b0;
`endif

    assign bus.READY             = ready_q;
    assign bus.P_DECODER_OUT     = pdec_q;
    assign bus.NOT_P_DECODER_OUT = ~pdec_q;
    assign bus.N_DECODER_OUT     = ndec_q;
    assign bus.NOT_N_DECODER_OUT = ~ndec_q;
    assign bus.Y_DECODER_OUT     = ydec_q;
    assign bus.P_EN_REF          = pref_q;
    assign bus.NOT_P_EN_REF      = ~pref_q;
    assign bus.WRITE_DATA        = wdata_q;
    assign bus.READ              = read_q;
    assign bus.WRITE             = write_q;
    assign bus.PRE               = pre_q;
    assign bus.DVLP              = dvlp_q;
    assign bus.EN_SA             = ensa_q;
    assign bus.DATA_OUT          = dout_q;
    assign bus.DATA_VALID        = dvalid_q;
    assign bus.WRITE_DONE        = wdone_q;
endmodule

// File: tb/tb_rram_ctrl_seq.sv
// Scoreboard bench for rram_ctrl_seq: default and long-phase instances.
// Completion events are checked by monitors against queued expectations.
module tb_rram_ctrl_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         rd;
        logic [1:0] d;
        bit         e;
        int         at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    rram_ctrl_seq_if #(.B_SIZE(2), .X_SIZE(4), .Y_SIZE(5)) bus0 ();
    rram_ctrl_seq_if #(.B_SIZE(2), .X_SIZE(4), .Y_SIZE(5)) bus1 ();

    rram_ctrl_seq u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    rram_ctrl_seq #(
        .PRE_CYCLES   (3),
        .DVLP_CYCLES  (2),
        .SENSE_CYCLES (2)
    ) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Sense-amp model: fixed value, or mismatch until pass match_at
    logic [1:0] sa0 = 2'b00;
    logic [1:0] sa1 = 2'b00;
    logic [1:0] wd = 2'b00;
    bit         vfy_on = 1'b0;
    int         match_at = 1;
    int         wpass = 0;
    logic       wprev = 1'b0;

    assign bus0.SA_OUT = vfy_on ? ((wpass >= match_at) ? wd : ~wd) : sa0;
    assign bus1.SA_OUT = sa1;

    always @(negedge clk) begin
        if (bus0.WRITE && !wprev) wpass++;
        wprev = bus0.WRITE;
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon(string nm, ref exp_t q[$], input logic dv,
                       input logic wdn, input logic [1:0] dout,
                       input logic err);
        exp_t e;
        if (q.size() == 0) begin
            chk({nm, "_unexpected"}, {dv, wdn}, 2'b00);
        end else begin
            e = q.pop_front();
            chk({nm, "_kind"}, {dv, wdn}, e.rd ? 2'b10 : 2'b01);
            chk({nm, "_cycle"}, 64'(cyc), 64'(e.at));
            chk({nm, "_err"}, err, e.e);
            if (e.rd) chk({nm, "_data"}, dout, e.d);
        end
    endtask

    // Completion monitors for both instances
    always @(negedge clk) begin
        if (reset && (bus0.DATA_VALID || bus0.WRITE_DONE))
            mon("u0", q0, bus0.DATA_VALID, bus0.WRITE_DONE,
                bus0.DATA_OUT, bus0.ERROR);
        if (reset && (bus1.DATA_VALID || bus1.WRITE_DONE))
            mon("u1", q1, bus1.DATA_VALID, bus1.WRITE_DONE,
                bus1.DATA_OUT, bus1.ERROR);
    end

    // Called at a negedge; returns at the negedge of cycle 0
    task automatic req0(bit rd, logic [3:0] x, logic [4:0] y,
                        logic [1:0] d, int lat, bit err,
                        logic [1:0] rexp);
        bus0.EN = 1'b1;
        bus0.RW = rd;
        bus0.X_ADDRESS_IN = x;
        bus0.Y_ADDRESS_IN = y;
        bus0.DATA_IN = d;
        q0.push_back('{rd, rexp, err, cyc + 1 + lat});
        @(negedge clk);
        bus0.EN = 1'b0;
    endtask

    task automatic drain0();
        for (int i = 0; i < 80 && q0.size() != 0; i++) @(negedge clk);
        chk("u0_drain", 64'(q0.size()), 64'd0);
    endtask

    task automatic drain1();
        for (int i = 0; i < 80 && q1.size() != 0; i++) @(negedge clk);
        chk("u1_drain", 64'(q1.size()), 64'd0);
    endtask

    int wlat;

    initial begin
        bus0.EN = 1'b0; bus0.RW = 1'b0;
        bus0.X_ADDRESS_IN = '0; bus0.Y_ADDRESS_IN = '0;
        bus0.DATA_IN = '0;
        bus1.EN = 1'b0; bus1.RW = 1'b0;
        bus1.X_ADDRESS_IN = '0; bus1.Y_ADDRESS_IN = '0;
        bus1.DATA_IN = '0;
`ifdef RRAM_CTRL_VERIFY_EN
        wlat = 5;
`else
        wlat = 2;
`endif

        // Reset and idle
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus0.READY, 1'b1);
        chk("rst_onehots", {bus0.P_DECODER_OUT, bus0.N_DECODER_OUT,
            bus0.Y_DECODER_OUT}, 64'd0);
        chk("rst_not_p", bus0.NOT_P_DECODER_OUT, 16'hFFFF);
        chk("rst_not_pref", bus0.NOT_P_EN_REF, 1'b1);
        chk("rst_strobes", {bus0.READ, bus0.WRITE, bus0.PRE, bus0.DVLP,
            bus0.EN_SA, bus0.P_EN_REF, bus0.ERROR}, 7'd0);

        // Write X=2 Y=4 D=10
        vfy_on = 1'b1; match_at = 1; wd = 2'b10; wpass = 0;
        req0(1'b0, 4'd2, 5'd4, 2'b10, wlat, 1'b0, 2'b00);
        chk("wr_p", bus0.P_DECODER_OUT, 16'h0004);
        chk("wr_n", bus0.N_DECODER_OUT, 16'h0004);
        chk("wr_not_n", bus0.NOT_N_DECODER_OUT, 16'hFFFB);
        chk("wr_y", bus0.Y_DECODER_OUT, 32'h10);
        chk("wr_c0", {bus0.WRITE, bus0.READY, bus0.WRITE_DATA}, 4'b1010);
        @(negedge clk);
        chk("wr_c1", bus0.WRITE, 1'b1);
        @(negedge clk);
        chk("wr_c2", bus0.WRITE, 1'b0);
        drain0();
        vfy_on = 1'b0;

        // Read at maximum address, then back-to-back read
        @(negedge clk);
        sa0 = 2'b01;
        req0(1'b1, 4'd15, 5'd31, 2'b00, 3, 1'b0, 2'b01);
        chk("rd_p", bus0.P_DECODER_OUT, 16'h8000);
        chk("rd_n", bus0.N_DECODER_OUT, 16'h0000);
        chk("rd_y", bus0.Y_DECODER_OUT, 32'h8000_0000);
        chk("rd_c0", {bus0.READ, bus0.PRE, bus0.DVLP, bus0.EN_SA,
            bus0.P_EN_REF}, 5'b11001);
        @(negedge clk);
        chk("rd_c1", {bus0.READ, bus0.PRE, bus0.DVLP, bus0.EN_SA,
            bus0.P_EN_REF}, 5'b10101);
        @(negedge clk);
        chk("rd_c2", {bus0.READ, bus0.PRE, bus0.DVLP, bus0.EN_SA,
            bus0.P_EN_REF}, 5'b10011);
        @(negedge clk);
        sa0 = 2'b11;
        req0(1'b1, 4'd1, 5'd0, 2'b00, 3, 1'b0, 2'b11);
        chk("b2b_c0", {bus0.READY, bus0.PRE, bus0.P_DECODER_OUT},
            {2'b01, 16'h0002});
        chk("b2b_hold", bus0.DATA_OUT, 2'b01);
        drain0();
        chk("rd_hold", bus0.DATA_OUT, 2'b11);

        // Long-phase instance with ignored EN mid-read
        sa1 = 2'b10;
        bus1.EN = 1'b1; bus1.RW = 1'b1;
        bus1.X_ADDRESS_IN = 4'd0; bus1.Y_ADDRESS_IN = 5'd0;
        q1.push_back('{1'b1, 2'b10, 1'b0, cyc + 1 + 7});
        @(negedge clk);
        bus1.EN = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("lp_c%0d", i), {bus1.PRE, bus1.DVLP, bus1.EN_SA},
                (i < 3) ? 3'b100 : (i < 5) ? 3'b010 : 3'b001);
            bus1.EN = (i == 2);
            bus1.RW = 1'b0;
            @(negedge clk);
        end
        bus1.EN = 1'b0;
        drain1();
        repeat (6) @(negedge clk);
        chk("lp_idle", {bus1.READY, bus1.WRITE}, 2'b10);

        // Reset during RPH2
        sa0 = 2'b01;
        req0(1'b1, 4'd3, 5'd2, 2'b00, 3, 1'b0, 2'b01);
        @(negedge clk);
        chk("mr_dvlp", bus0.DVLP, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mr_ready", bus0.READY, 1'b1);
        chk("mr_strobes", {bus0.READ, bus0.DVLP, bus0.P_EN_REF},
            3'b000);
        chk("mr_dec", {bus0.P_DECODER_OUT, bus0.Y_DECODER_OUT}, 48'd0);
        chk("mr_not", {bus0.NOT_P_DECODER_OUT, bus0.NOT_P_EN_REF},
            {16'hFFFF, 1'b1});
        chk("mr_dout", bus0.DATA_OUT, 2'b00);
        q0.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sa0 = 2'b10;
        req0(1'b1, 4'd5, 5'd7, 2'b00, 3, 1'b0, 2'b10);
        drain0();
        chk("mr_next", bus0.DATA_OUT, 2'b10);

`ifdef RRAM_CTRL_VERIFY_EN
        // Verify: two mismatches then match
        @(negedge clk);
        vfy_on = 1'b1; wd = 2'b01; match_at = 3; wpass = 0;
        req0(1'b0, 4'd1, 5'd1, 2'b01, 15, 1'b0, 2'b00);
        drain0();
        chk("vfy_pass3", 64'(wpass), 64'd3);

        // Verify: always mismatch
        @(negedge clk);
        match_at = 99; wpass = 0;
        req0(1'b0, 4'd1, 5'd1, 2'b01, 20, 1'b1, 2'b00);
        drain0();
        chk("vfy_pass4", 64'(wpass), 64'd4);
        vfy_on = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rram_ctrl_seq.md
# rram_ctrl_seq

Parametrised sequencing controller for the RRAM array macro, and the successor to the fixed-phase array controller. It accepts one read or write request at a time and drives the same array-side control set: one-hot P/N/Y decoders, READ, WRITE, PRE, DVLP and EN_SA. Phase lengths are programmable. It adds a READY/DONE handshake, sense-amp data capture and an optional program-and-verify loop. It sits between the host-side memory interface and the analog array periphery.

## Interface
Parameters:
- B_SIZE, 2, word width in bits
- X_SIZE, 4, word-column address bits (2^X_SIZE word columns)
- Y_SIZE, 5, select-line address bits (2^Y_SIZE SEL lines)
- PRE_CYCLES, 1, precharge phase length in cycles (≥1)
- DVLP_CYCLES, 1, develop phase length in cycles (≥1)
- SENSE_CYCLES, 1, sense phase length in cycles (≥1)
- WRITE_CYCLES, 2, write pulse length in cycles (≥1)
- MAX_RETRY, 3, verify rewrite attempts (used only with the verify macro)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- EN  in  1  request strobe
- RW  in  1  1 = read, 0 = write
- X_ADDRESS_IN  in  X_SIZE  word-column address
- Y_ADDRESS_IN  in  Y_SIZE  select-line address
- DATA_IN  in  B_SIZE  write data
- SA_OUT  in  B_SIZE  sense-amplifier outputs
- READY  out  1  controller idle and able to accept EN
- P_DECODER_OUT / NOT_P_DECODER_OUT  out  2^X_SIZE  P-side one-hot and its complement
- N_DECODER_OUT / NOT_N_DECODER_OUT  out  2^X_SIZE  N-side one-hot and its complement
- Y_DECODER_OUT  out  2^Y_SIZE  SEL one-hot
- P_EN_REF / NOT_P_EN_REF  out  1  reference column enable and its complement
- WRITE_DATA  out  B_SIZE  latched write data
- READ, WRITE, PRE, DVLP, EN_SA  out  1  array phase strobes
- DATA_OUT  out  B_SIZE  captured read data
- DATA_VALID  out  1  one-cycle read-complete pulse
- WRITE_DONE  out  1  one-cycle write-complete pulse
- ERROR  out  1  verify failure, valid together with WRITE_DONE

## Operation
- **States and encoding:** IDLE=000, RPH1=001, RPH2=010, RPH3=011, WPH1=100, plus VFY=101 when verify is compiled in. A down-counter times each phase.
- **Accept:** EN=1 at a rising edge while READY=1 accepts the request.
  - X, Y, RW and DATA_IN are latched.
  - The state moves to RPH1 if RW=1, else WPH1.
  - EN while READY=0 is ignored; there is no queue.
- **Read path:**
  - RPH1 asserts READ and PRE for PRE_CYCLES.
  - RPH2 asserts READ and DVLP for DVLP_CYCLES.
  - RPH3 asserts READ and EN_SA for SENSE_CYCLES.
  - On the last RPH3 edge, SA_OUT is captured into DATA_OUT, the state goes to IDLE and DATA_VALID pulses high for 1 cycle.
- **Write path:** WPH1 asserts WRITE and drives WRITE_DATA for WRITE_CYCLES, then goes to IDLE and pulses WRITE_DONE.
- **Decoders:**
  - Y_DECODER_OUT = 1<<Y in every non-IDLE state.
  - P_DECODER_OUT = 1<<X in read and write states.
  - N_DECODER_OUT = 1<<X in WPH1 only.
  - P_EN_REF = 1 in RPH1–RPH3 only.
  - In IDLE all one-hots are 0. Every NOT_ output is the bitwise complement of its partner at all times.
- DATA_OUT holds its value until the next read capture.

## Timing
- All outputs are registered and change only on rising clk edges, except at reset.
- **Reset (reset=0, asynchronous, takes effect immediately, including mid-operation):**
  - state = IDLE, READY = 1.
  - All strobes, one-hots, P_EN_REF, DATA_VALID, WRITE_DONE and ERROR = 0.
  - All NOT_ outputs and NOT_P_EN_REF = 1.
  - DATA_OUT = 0, WRITE_DATA = 0, counters = 0.
- **Accept edge T0:** the decoders and the first phase are valid from T0 until the next edge; READY drops at T0.
- **Read:** DATA_VALID is high in cycle T0+PRE+DVLP+SENSE, and READY rises in that same cycle. With defaults, RPH1/2/3 occupy cycles 0/1/2 and DATA_VALID is in cycle 3.
- **Write:** WRITE_DONE is high in cycle T0+WRITE_CYCLES.
- **Back-to-back:** EN may be asserted in the DATA_VALID/WRITE_DONE cycle and is accepted at the following edge, so there is no dead cycle.
- **Counter width:** clog2 of the maximum phase parameter plus 1. There is no wrap: the counter reloads on every phase entry.

## Configuration
- **RRAM_CTRL_VERIFY_EN defined:** after WPH1 the state goes to VFY, which runs the RPH1–RPH3 strobe sequence with P_EN_REF=1. On the last sense edge, SA_OUT is compared with WRITE_DATA:
  - Match: go to IDLE, WRITE_DONE=1, ERROR=0.
  - Mismatch with retries < MAX_RETRY: increment the retry count and re-enter WPH1.
  - Mismatch with retries = MAX_RETRY: go to IDLE, WRITE_DONE=1, ERROR=1.
  - The retry count clears on accept.
- **Not defined:** VFY does not exist, WPH1 goes directly to IDLE, and ERROR is tied to 0.

## Test plan
- **Reset and idle:** release reset with EN=0. Required: READY=1, all one-hots 0, NOT_P_DECODER_OUT=16'hFFFF, NOT_P_EN_REF=1.
- **Write:** write X=2, Y=4, DATA_IN=2'b10. Required:
  - P_DECODER_OUT=16'h0004, N_DECODER_OUT=16'h0004, Y_DECODER_OUT=32'h10, WRITE=1 for 2 cycles.
  - WRITE_DONE in cycle 2.
- **Read at maximum address:** read X=15, Y=31 with SA_OUT=2'b01. Required:
  - P_DECODER_OUT=16'h8000, P_EN_REF=1.
  - States RPH1, RPH2, RPH3 on successive cycles.
  - DATA_OUT=2'b01 with DATA_VALID in cycle 3.
- **Non-default phase lengths:** set PRE_CYCLES=3, DVLP_CYCLES=2, SENSE_CYCLES=2. Required: PRE high for 3 cycles, DVLP for 2, EN_SA for 2, DATA_VALID in cycle 7. An EN pulse mid-read is ignored.
- **Mid-read reset:** assert reset during RPH2. Required: all outputs return to their reset values immediately, and the next read completes normally.
- **Verify (RRAM_CTRL_VERIFY_EN):**
  - SA_OUT mismatches twice, then matches: required 3 WPH1 passes, WRITE_DONE=1, ERROR=0.
  - SA_OUT always mismatches: required 4 WPH1 passes, then WRITE_DONE=1 and ERROR=1.
